// File: rtl/timer_pkg.sv
// Shared types and flag bit positions for the general-purpose timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  localparam int FLAG_UPD = 0;
  localparam int FLAG_CC0 = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable generator: one-cycle tick every psc+1 cycles while run is high.
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  logic [PSC_W-1:0] pre;

  assign tick = run && (pre == psc);

  // Parked at zero outside RUN so every run starts a fresh prescale period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (!run || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PSC_ONE;
    end
  end

endmodule

// File: rtl/gp_timer.sv
// General-purpose up/down timer with prescaler, shadowed reload,
// compare channels, sticky flags, PWM outputs and interrupt.
module gp_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PSC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    one_shot,
  input  logic                    countdown,
  input  logic [PSC_W-1:0]        psc,
  input  logic [CNT_W-1:0]        arr,
  input  logic [NUM_CH*CNT_W-1:0] ccr,
  input  logic [NUM_CH:0]         ier,
  input  logic [NUM_CH:0]         flag_clr,
  output logic [CNT_W-1:0]        cnt_o,
  output logic [NUM_CH:0]         flags,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    irq,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  timer_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PSC_W-1:0] psc_sh;
  logic [CNT_W-1:0] arr_sh;
  logic             dir_sh;
  logic             os_sh;
  logic             run;
  logic             tick;
  logic             upd;
  logic [NUM_CH:0]  flag_set;

  assign run   = (state == RUN);
  assign busy  = run;
  assign cnt_o = cnt;

  timer_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .psc  (psc_sh),
    .tick (tick)
  );

  always_comb begin
    cnt_nxt = cnt;
    upd     = 1'b0;
    if (run && tick) begin
      if (!dir_sh) begin
        if (cnt == arr_sh) begin
          cnt_nxt = '0;
          upd     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end else begin
        if (cnt == '0) begin
          cnt_nxt = arr_sh;
          upd     = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
               else if (upd && os_sh) state_nxt = DONE;
      DONE:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Compare channels beyond the active reload value are masked off.
  always_comb begin
    flag_set           = '0;
    flag_set[FLAG_UPD] = upd;
    for (int i = 0; i < NUM_CH; i++) begin
      flag_set[FLAG_CC0+i] = run && tick
                             && (cnt_nxt == ccr[i*CNT_W +: CNT_W])
                             && (ccr[i*CNT_W +: CNT_W] <= arr_sh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      psc_sh <= '0;
      arr_sh <= '0;
      dir_sh <= 1'b0;
      os_sh  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && en) begin
        psc_sh <= psc;
        arr_sh <= arr;
        dir_sh <= countdown;
        os_sh  <= one_shot;
        cnt    <= countdown ? arr : '0;
      end else begin
        cnt <= cnt_nxt;
        if (upd) begin
          psc_sh <= psc;
          arr_sh <= arr;
          dir_sh <= countdown;
          os_sh  <= one_shot;
        end
      end
    end
  end

  // A set in the same cycle as its clear pulse takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags   <= '0;
      irq     <= 1'b0;
      pwm_out <= '0;
    end else begin
      flags <= (flags & ~flag_clr) | flag_set;
      irq   <= |(flags & ier);
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= run && (cnt < ccr[i*CNT_W +: CNT_W]);
      end
    end
  end

endmodule

// File: tb/tb_gp_timer.sv
// Directed bench for gp_timer with NUM_CH=2: counting, one-shot,
// PWM, shadowed reload, flag clear priority and reset.
module tb_gp_timer;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int PSC_W  = 16;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    one_shot;
  logic                    countdown;
  logic [PSC_W-1:0]        psc;
  logic [CNT_W-1:0]        arr;
  logic [NUM_CH*CNT_W-1:0] ccr;
  logic [NUM_CH:0]         ier;
  logic [NUM_CH:0]         flag_clr;
  logic [CNT_W-1:0]        cnt_o;
  logic [NUM_CH:0]         flags;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    irq;
  logic                    busy;

  int n_chk;
  int n_err;
  int n_pwm0;
  int n_pwm1;

  gp_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .one_shot  (one_shot),
    .countdown (countdown),
    .psc       (psc),
    .arr       (arr),
    .ccr       (ccr),
    .ier       (ier),
    .flag_clr  (flag_clr),
    .cnt_o     (cnt_o),
    .flags     (flags),
    .pwm_out   (pwm_out),
    .irq       (irq),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; en = 1'b0; one_shot = 1'b0; countdown = 1'b0;
    psc = '0; arr = '0; ccr = '0; ier = '0; flag_clr = '0;
    #1;
    chk("rst_cnt", cnt_o, 0);
    chk("rst_flags", flags, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    step(2);
    rst = 1'b0;

    // Up-count, psc=3, arr=4: one count step every 4 cycles
    psc = 16'd3; arr = 16'd4; ccr = {16'd7, 16'd2}; ier = 3'b001; en = 1'b1;
    step(1);
    chk("t1_busy", busy, 1);
    chk("t1_cnt0", cnt_o, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("t1_cnt", cnt_o, (k / 4) % 5);
      chk("t1_flag_upd", flags[0], (k >= 20) ? 1 : 0);
    end
    chk("t1_flag_cc0", flags[1], 1);
    chk("t1_flag_cc1", flags[2], 0);
    chk("t1_irq_lag", irq, 0);
    step(1);
    chk("t1_irq", irq, 1);
    en = 1'b0; flag_clr = 3'b111;
    step(1);
    flag_clr = 3'b000;
    chk("t1_idle_busy", busy, 0);
    chk("t1_clr", flags, 0);
    step(1);
    chk("t1_irq_off", irq, 0);
    chk("t1_idle_cnt", cnt_o, 0);

    // Down-count one-shot, arr=5, psc=0
    countdown = 1'b1; arr = 16'd5; psc = 16'd0; one_shot = 1'b1; ier = 3'b000; en = 1'b1;
    step(1);
    chk("t2_cnt0", cnt_o, 5);
    chk("t2_busy0", busy, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("t2_cnt", cnt_o, (k < 6) ? 5 - k : 5);
      chk("t2_busy", busy, (k < 6) ? 1 : 0);
    end
    chk("t2_flag_upd", flags[0], 1);
    step(3);
    chk("t2_done_cnt", cnt_o, 5);
    chk("t2_done_busy", busy, 0);
    en = 1'b0;
    step(1);
    chk("t2_idle_cnt", cnt_o, 5);
    one_shot = 1'b0; flag_clr = 3'b111;
    step(1);
    flag_clr = 3'b000;

    // PWM: arr=9, ccr0=3, ccr1=12 over two full periods
    countdown = 1'b0; arr = 16'd9; psc = 16'd0; ccr = {16'd12, 16'd3}; en = 1'b1;
    step(1);
    chk("t3_cnt0", cnt_o, 0);
    n_pwm0 = 0; n_pwm1 = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("t3_cnt", cnt_o, k % 10);
      n_pwm0 += int'(pwm_out[0]);
      n_pwm1 += int'(pwm_out[1]);
    end
    chk("t3_pwm0_high", n_pwm0, 6);
    chk("t3_pwm1_high", n_pwm1, 20);
    chk("t3_flag_cc1", flags[2], 0);
    chk("t3_flag_cc0", flags[1], 1);

    // Shadowed reload: arr 9->4 mid-period
    step(2);
    chk("t4_cnt_mid", cnt_o, 2);
    arr = 16'd4;
    for (int k = 23; k <= 36; k++) begin
      step(1);
      chk("t4_cnt", cnt_o, (k < 30) ? k - 20 : (k - 30) % 5);
    end
    chk("t4_flag_cc1", flags[2], 0);

    // Clear without event, then clear colliding with an update event
    flag_clr = 3'b001;
    step(1);
    chk("t5_clr_alone", flags[0], 0);
    flag_clr = 3'b000;
    step(2);
    chk("t5_cnt_pre", cnt_o, 4);
    flag_clr = 3'b001;
    step(1);
    flag_clr = 3'b000;
    chk("t5_set_wins", flags[0], 1);
    chk("t5_cnt_wrap", cnt_o, 0);
    ier = 3'b001;
    step(1);
    chk("t5_irq", irq, 1);
    chk("t5_busy", busy, 1);
    chk("t5_pwm", pwm_out, 2'b11);

    // Asynchronous reset mid-RUN
    rst = 1'b1;
    #1;
    chk("t6_cnt", cnt_o, 0);
    chk("t6_flags", flags, 0);
    chk("t6_pwm", pwm_out, 0);
    chk("t6_irq", irq, 0);
    chk("t6_busy", busy, 0);
    countdown = 1'b1; arr = 16'd7;
    step(2);
    chk("t6_held_cnt", cnt_o, 0);
    chk("t6_held_busy", busy, 0);
    rst = 1'b0;
    chk("t6_rel_busy", busy, 0);
    step(1);
    chk("t6_restart_busy", busy, 1);
    chk("t6_restart_cnt", cnt_o, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
